// File: rtl/mem_rsp_model.sv
// Single-beat memory responder with per-word written bits, fixed read latency
// and a walking clear. Define MEM_RSP_WR_ACK_EN to also acknowledge writes.
module mem_rsp_model #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              clear,
   output logic              busy,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_wr,
   output logic [7:0]        err_count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DEPTH-1:0]    wr_bit_q, wr_bit_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]   pipe_err_q, pipe_err_d;
   logic [DATA_W-1:0]   pipe_data_q [RD_LAT];
   logic [DATA_W-1:0]   pipe_data_d [RD_LAT];
   logic [7:0]          err_count_q, err_count_d;
   logic                accept;
   logic                acc_rd;
   logic                acc_wr;
   logic                hit;
`ifdef MEM_RSP_WR_ACK_EN
   logic [RD_LAT-1:0]   pipe_wr_q, pipe_wr_d;
`endif

   // clear wins over a same-cycle request; the walk blocks all traffic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_bit_d  = wr_bit_q;
      req_ready = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (clear) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
            end else begin
               accept = req_valid;
            end
         end
         ST_CLEAR: begin
            busy            = 1'b1;
            wr_bit_d[idx_q] = 1'b0;
            idx_d           = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      acc_wr = accept && req_write;
      acc_rd = accept && !req_write;
      if (acc_wr) begin
         wr_bit_d[req_addr] = 1'b1;
      end
   end

   // response pipeline: stage 0 captures data and error status at acceptance
   always_comb begin
      hit        = wr_bit_q[req_addr];
      pipe_vld_d = '0;
      pipe_err_d = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_data_d[i] = '0;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_err_d[i]  = pipe_err_q[i-1];
         pipe_data_d[i] = pipe_data_q[i-1];
      end
`ifdef MEM_RSP_WR_ACK_EN
      pipe_wr_d = '0;
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_wr_d[i] = pipe_wr_q[i-1];
      end
      pipe_wr_d[0]  = acc_wr;
      pipe_vld_d[0] = accept;
`else
      pipe_vld_d[0] = acc_rd;
`endif
      pipe_err_d[0]  = acc_rd && !hit;
      pipe_data_d[0] = (acc_rd && hit) ? mem_q[req_addr] : '0;
      err_count_d    = err_count_q;
      if (pipe_vld_d[RD_LAT-1] && pipe_err_d[RD_LAT-1] && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // data array is deliberately left unreset
   always_ff @(posedge clk) begin
      if (acc_wr) begin
         mem_q[req_addr] <= req_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         wr_bit_q    <= '0;
         pipe_vld_q  <= '0;
         pipe_err_q  <= '0;
         err_count_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_data_q[i] <= '0;
         end
`ifdef MEM_RSP_WR_ACK_EN
         pipe_wr_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wr_bit_q    <= wr_bit_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_err_q  <= pipe_err_d;
         err_count_q <= err_count_d;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
         end
`ifdef MEM_RSP_WR_ACK_EN
         pipe_wr_q   <= pipe_wr_d;
`endif
      end
   end

   assign rsp_valid = pipe_vld_q[RD_LAT-1];
   assign rsp_err   = pipe_err_q[RD_LAT-1];
   assign rsp_rdata = pipe_data_q[RD_LAT-1];
   assign err_count = err_count_q;
`ifdef MEM_RSP_WR_ACK_EN
   assign rsp_wr    = pipe_wr_q[RD_LAT-1];
`else
   assign rsp_wr    = 1'b0;
`endif

endmodule
